// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: prefix bytes, frame length, FSM states and
// the movement-key scan codes used by the downstream flag block.
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0]  KEY_W = 8'h1D;
    localparam logic [7:0]  KEY_A = 8'h1C;
    localparam logic [7:0]  KEY_S = 8'h1B;
    localparam logic [7:0]  KEY_D = 8'h23;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        EMIT
    } ps2_state_t;

    // Odd parity over data byte plus parity bit.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data lines into the system clock domain
// and flags the falling edge of the synchronised PS/2 clock.
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;

    // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: frames 11-bit packets, validates them, folds F0/E0
// prefixes into flags and emits one pulse per key event.
module ps2_rx_controller
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       PS2_CLOCK,
    input  logic       PS2_DATA,
    output logic [7:0] code_out,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         LAST_CNT   = 4'(PS2_FRAME_BITS - 1);

    ps2_state_t         state, state_nxt;
    logic               fall, data_s;
    logic [3:0]         bit_cnt;
    logic [9:0]         shift;
    logic [TIMER_W-1:0] timer;
    logic               pend_brk, pend_ext;
    logic               frame_ok, is_prefix, timeout;
    logic [7:0]         rx_byte;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (CLOCK_50),
        .rst      (RESET),
        .ps2_clk  (PS2_CLOCK),
        .ps2_data (PS2_DATA),
        .fall     (fall),
        .data_s   (data_s)
    );

    assign rx_byte   = shift[7:0];
    assign frame_ok  = odd_parity_ok(shift[8:0]) && shift[9];
    assign is_prefix = (rx_byte == PS2_BREAK) || (rx_byte == PS2_EXT);
    assign timeout   = (state == RECV) && !fall && (timer == TIMER_LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !data_s) state_nxt = RECV;
            RECV:    if (fall && bit_cnt == LAST_CNT) state_nxt = CHECK;
                     else if (timeout)                state_nxt = IDLE;
            CHECK:   state_nxt = (frame_ok && !is_prefix) ? EMIT : IDLE;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        code_valid  = (state == EMIT);
        frame_error = ((state == CHECK) && !frame_ok) || timeout;
        busy        = (state != IDLE);
    end

    // Decoded outputs are latched in CHECK so they are already stable during EMIT.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            bit_cnt     <= '0;
            shift       <= '0;
            timer       <= '0;
            pend_brk    <= 1'b0;
            pend_ext    <= 1'b0;
            code_out    <= '0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !data_s) begin
                        bit_cnt <= 4'd1;
                        timer   <= '0;
                        shift   <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shift   <= {data_s, shift[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        timer   <= '0;
                    end else if (timeout) begin
                        shift    <= '0;
                        bit_cnt  <= '0;
                        pend_brk <= 1'b0;
                        pend_ext <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    bit_cnt <= '0;
                    if (!frame_ok) begin
                        pend_brk <= 1'b0;
                        pend_ext <= 1'b0;
                    end else if (rx_byte == PS2_BREAK) begin
                        pend_brk <= 1'b1;
                    end else if (rx_byte == PS2_EXT) begin
                        pend_ext <= 1'b1;
                    end else begin
                        code_out    <= rx_byte;
                        is_break    <= pend_brk;
                        is_extended <= pend_ext;
                    end
                end
                EMIT: begin
                    pend_brk <= 1'b0;
                    pend_ext <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
